freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
// Gated-window frequency counter for the logic-analyser front end; inverse of the sample-clock divider.
// Counts rising edges of an asynchronous probe input over a selectable gate window derived from iSysClk.
// Reports the result in Hz, plus high-time cycles over the same window.
// Sits beside the capture path; results feed the UART/host status registers.
// PARAMETERS
// SYS_CLK_HZ  50_000_000  iSysClk frequency in Hz; must be divisible by 1000
// SYNC_STAGES 2           synchroniser flops on sig_in (>=2)
// PORTS
// iSysClk     in   1   system clock
// iRst        in   1   asynchronous reset, active-high
// sig_in      in   1   probe signal, asynchronous to iSysClk
// start       in   1   one-cycle request to begin a measurement
// cont        in   1   1 = re-arm automatically after each result
// gate_sel    in   2   0:1 s  1:100 ms  2:10 ms  3:1 ms
// freq_hz     out  32  last measured frequency in Hz
// high_cnt    out  32  iSysClk cycles sig_in was high during the last gate
// meas_valid  out  1   one-cycle pulse when freq_hz/high_cnt are updated
// busy        out  1   high while a gate is open or a result is being produced
// BEHAVIOUR
// - Reset (async, iRst=1): state IDLE; freq_hz, high_cnt, internal counters = 0; meas_valid=0, busy=0; synchroniser flops cleared.
// - sig_in passes through SYNC_STAGES flops, then a rising-edge detector (one more flop).
//   The detector runs continuously, in every state.
// - Gate length G = SYS_CLK_HZ / {1,10,100,1000}[gate_sel]. Multiplier M = {1,10,100,1000}[gate_sel].
// - FSM states:
//   IDLE: busy=0. start=1 -> GATE. Entry actions: latch gate_sel, clear edge_cnt, gate_cnt, hi_cnt.
//   GATE: busy=1. Each cycle gate_cnt++.
//     If an edge is detected, edge_cnt++. If the synchronised level is 1, hi_cnt++.
//     The gate closes on the cycle gate_cnt == G-1; that cycle is counted. Then go to DONE.
//   DONE (1 cycle): busy=1. Register freq_hz = edge_cnt*M (shift-add, 32-bit) and high_cnt = hi_cnt.
//     Pulse meas_valid in that same output-register cycle.
//     Next state: if cont=1, go to GATE and re-latch gate_sel (counters cleared); otherwise go to IDLE.
// - Latency: start in cycle 0 -> first gate cycle is cycle 1 -> meas_valid in cycle G+2.
// - Edges or high levels sampled during the DONE cycle are not counted (1-cycle dead time per result).
// - start while busy=1 is ignored. gate_sel changes mid-gate take effect only at the next gate.
// - cont falling mid-gate: the current gate completes and reports, then the FSM returns to IDLE.
// - sig_in static: freq_hz=0. high_cnt=0 if static low; G if static high.
// - Measurable range is below SYS_CLK_HZ/2; edge_cnt cannot exceed G/2, so no overflow handling is required.
// - Reset mid-gate aborts the measurement; no meas_valid is issued.
// - freq_hz/high_cnt hold their last values until the next DONE.
// STRUCTURE
// - Shared package freq_meter_pkg: FSM state encoding (IDLE/GATE/DONE), GATE_DIV table {1,10,100,1000}, gate_sel codes.
// - Sub-module sync_edge_det (SYNC_STAGES synchroniser + rising-edge pulse + synchronised level output).
// - Top level holds the FSM, the 32-bit gate/edge/high counters, and the constant multiply.
// TESTING (bench uses SYS_CLK_HZ=100_000, i.e. 1 s gate = 100000 cycles)
// - Reset, then idle: all outputs 0, busy=0. Assert iRst mid-gate -> busy drops immediately and no meas_valid follows.
// - sig_in = iSysClk/10 (10 kHz, 50% duty), gate_sel=0, start pulse:
//   meas_valid at cycle 100002; freq_hz=10000 +/-1; high_cnt=50000 +/-5.
// - Same sig_in, gate_sel=3 (100-cycle gate):
//   freq_hz=10000 +/-1000 (10 edges, each worth x1000); meas_valid at start+102.
// - cont=1, gate_sel=3, sig_in period 4:
//   meas_valid every 101 cycles; freq_hz=25000 every result; deassert cont -> exactly one more result, then busy=0.
// - start pulsed during GATE and gate_sel changed mid-gate:
//   the start is ignored, the result uses the latched gate_sel, and there is a single meas_valid.
// - sig_in held 1 then held 0 across two gate_sel=3 runs:
//   results are freq_hz=0 with high_cnt=100, then freq_hz=0 with high_cnt=0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated-window frequency meter.
package freq_meter_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // gate_sel codes
    localparam logic [1:0] GSEL_1S    = 2'd0;
    localparam logic [1:0] GSEL_100MS = 2'd1;
    localparam logic [1:0] GSEL_10MS  = 2'd2;
    localparam logic [1:0] GSEL_1MS   = 2'd3;

    // Gate divider table: gate length is SYS_CLK_HZ / gate_div(sel).
    function automatic int unsigned gate_div(input logic [1:0] sel);
        case (sel)
            GSEL_1S:    return 1;
            GSEL_100MS: return 10;
            GSEL_10MS:  return 100;
            default:    return 1000;
        endcase
    endfunction

    // Edge count to Hz: multiply by the same table value using shifts and adds only.
    function automatic logic [CNT_W-1:0] scale_count(input logic [CNT_W-1:0] x, input logic [1:0] sel);
        case (sel)
            GSEL_1S:    return x;
            GSEL_100MS: return (x << 3) + (x << 1);
            GSEL_10MS:  return (x << 6) + (x << 5) + (x << 2);
            default:    return (x << 9) + (x << 8) + (x << 7) + (x << 6) + (x << 5) + (x << 3);
        endcase
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous probe plus rising-edge detector.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic level,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one delay flop for edge detection; runs in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts probe rising edges and high cycles over a selectable gate.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned SYS_CLK_HZ  = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             iSysClk,
    input  logic             iRst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] freq_hz,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             busy
);

    localparam int unsigned GATE_1S    = SYS_CLK_HZ / gate_div(GSEL_1S);
    localparam int unsigned GATE_100MS = SYS_CLK_HZ / gate_div(GSEL_100MS);
    localparam int unsigned GATE_10MS  = SYS_CLK_HZ / gate_div(GSEL_10MS);
    localparam int unsigned GATE_1MS   = SYS_CLK_HZ / gate_div(GSEL_1MS);

    // Index of the last gate cycle for a given selection.
    function automatic logic [CNT_W-1:0] gate_last(input logic [1:0] sel);
        case (sel)
            GSEL_1S:    return CNT_W'(GATE_1S - 1);
            GSEL_100MS: return CNT_W'(GATE_100MS - 1);
            GSEL_10MS:  return CNT_W'(GATE_10MS - 1);
            default:    return CNT_W'(GATE_1MS - 1);
        endcase
    endfunction

    state_t           state;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] gate_end;
    logic [CNT_W-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             level;
    logic             rise_c;
    logic             arm_c;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (iSysClk),
        .rst    (iRst),
        .sig_in (sig_in),
        .level  (level),
        .rise_c (rise_c)
    );

    // A new gate opens on an idle start or on automatic re-arm after a result.
    assign arm_c = ((state == ST_IDLE) && start) || ((state == ST_DONE) && cont);

    // Measurement FSM with counters and registered results.
    always_ff @(posedge iSysClk or posedge iRst) begin
        if (iRst) begin
            state      <= ST_IDLE;
            sel_q      <= GSEL_1S;
            gate_end   <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            hi_cnt     <= '0;
            freq_hz    <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                ST_GATE: begin
                    gate_cnt <= gate_cnt + CNT_W'(1);
                    if (rise_c) edge_cnt <= edge_cnt + CNT_W'(1);
                    if (level)  hi_cnt   <= hi_cnt + CNT_W'(1);
                    if (gate_cnt == gate_end) state <= ST_DONE;
                end
                ST_DONE: begin
                    freq_hz    <= scale_count(edge_cnt, sel_q);
                    high_cnt   <= hi_cnt;
                    meas_valid <= 1'b1;
                    if (!cont) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (arm_c) begin
                state    <= ST_GATE;
                sel_q    <= gate_sel;
                gate_end <= gate_last(gate_sel);
                gate_cnt <= '0;
                edge_cnt <= '0;
                hi_cnt   <= '0;
                busy     <= 1'b1;
            end
        end
    end

endmodule
